// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: video mode constants and sizing helpers for vga_timing_gen.
package vga_timing_pkg;
  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
    bit h_pol;
    bit v_pol;
  } vga_mode_t;

  localparam vga_mode_t MODE_640X480_60 = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
  localparam vga_mode_t MODE_800X600_72 = '{800, 56, 120, 64, 600, 37, 6, 23, 1'b1, 1'b1};

  function automatic int total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int h_total(input vga_mode_t m);
    return total(m.h_active, m.h_fp, m.h_sync, m.h_bp);
  endfunction

  function automatic int v_total(input vga_mode_t m);
    return total(m.v_active, m.v_fp, m.v_sync, m.v_bp);
  endfunction

  function automatic int cw_for(input int h_tot, input int v_tot);
    return $clog2(h_tot > v_tot ? h_tot : v_tot);
  endfunction
endpackage

// File: rtl/vga_pix_tick.sv
// vga_pix_tick: divides clk by CLK_DIV into a registered one-clk pixel strobe.
module vga_pix_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic clear,
  output logic pix_tick
);
  localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic pix_tick_q, pix_tick_d;

  always_comb begin
    pre_d = (pre_q == LAST) ? '0 : pre_q + 1'b1;
    pix_tick_d = pre_d == LAST;
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      pre_q <= '0;
      pix_tick_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      pix_tick_q <= pix_tick_d;
    end
  end

  assign pix_tick = pix_tick_q;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster counters, syncs, bright flag and line/frame strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = MODE_640X480_60.h_active,
  parameter int H_FP       = MODE_640X480_60.h_fp,
  parameter int H_SYNC     = MODE_640X480_60.h_sync,
  parameter int H_BP       = MODE_640X480_60.h_bp,
  parameter int V_ACTIVE   = MODE_640X480_60.v_active,
  parameter int V_FP       = MODE_640X480_60.v_fp,
  parameter int V_SYNC     = MODE_640X480_60.v_sync,
  parameter int V_BP       = MODE_640X480_60.v_bp,
  parameter bit H_SYNC_POL = MODE_640X480_60.h_pol,
  parameter bit V_SYNC_POL = MODE_640X480_60.v_pol,
  parameter int CLK_DIV    = 2,
  parameter int CW         = 10
) (
  input  logic          clk,
  input  logic          clear,
  output logic          hsync,
  output logic          vsync,
  output logic          bright,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          pix_tick,
  output logic          line_start,
  output logic          frame_start
);
  localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic          tick, h_end, v_end;
  logic [CW-1:0] hcount_q, hcount_d, vcount_q, vcount_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d, bright_q, bright_d;
  logic          line_start_q, line_start_d, frame_start_q, frame_start_d;

  vga_pix_tick #(.CLK_DIV(CLK_DIV)) u_pix_tick (
    .clk      (clk),
    .clear    (clear),
    .pix_tick (tick)
  );

  // Decode from the next-state counters so syncs and bright line up with hcount/vcount.
  always_comb begin
    h_end = hcount_q == H_LAST;
    v_end = vcount_q == V_LAST;
    line_start_d = tick && h_end;
    frame_start_d = line_start_d && v_end;
    hcount_d = !tick ? hcount_q : h_end ? '0 : hcount_q + 1'b1;
    vcount_d = !line_start_d ? vcount_q : v_end ? '0 : vcount_q + 1'b1;
    hsync_d = (hcount_d >= HS_BEG && hcount_d <= HS_END) ? H_SYNC_POL : ~H_SYNC_POL;
    vsync_d = (vcount_d >= VS_BEG && vcount_d <= VS_END) ? V_SYNC_POL : ~V_SYNC_POL;
    bright_d = hcount_d < H_VIS && vcount_d < V_VIS;
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      hcount_q <= H_LAST;
      vcount_q <= V_LAST;
      hsync_q <= ~H_SYNC_POL;
      vsync_q <= ~V_SYNC_POL;
      bright_q <= 1'b0;
      line_start_q <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      bright_q <= bright_d;
      line_start_q <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcount = hcount_q;
  assign vcount = vcount_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign bright = bright_q;
  assign pix_tick = tick;
  assign line_start = line_start_q;
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboarded line events for the 640x480 default and a tiny CLK_DIV=1 mode.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic clr_d = 1'b1;
  logic clr_s = 1'b1;
  logic sel = 1'b0;
  always #5 clk = ~clk;

  logic       d_hs, d_vs, d_br, d_pt, d_ls, d_fs;
  logic [9:0] d_hc, d_vc;
  logic       s_hs, s_vs, s_br, s_pt, s_ls, s_fs;
  logic [3:0] s_hc, s_vc;

  vga_timing_gen dut_d (
    .clk(clk), .clear(clr_d), .hsync(d_hs), .vsync(d_vs), .bright(d_br),
    .hcount(d_hc), .vcount(d_vc), .pix_tick(d_pt), .line_start(d_ls), .frame_start(d_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CLK_DIV(1), .CW(4)
  ) dut_s (
    .clk(clk), .clear(clr_s), .hsync(s_hs), .vsync(s_vs), .bright(s_br),
    .hcount(s_hc), .vcount(s_vc), .pix_tick(s_pt), .line_start(s_ls), .frame_start(s_fs)
  );

  logic       clr, hs, vs, br, pt, ls, fs, pol;
  logic [9:0] hc, vc;
  always_comb begin
    clr = sel ? clr_s : clr_d;
    hs = sel ? s_hs : d_hs;
    vs = sel ? s_vs : d_vs;
    br = sel ? s_br : d_br;
    pt = sel ? s_pt : d_pt;
    ls = sel ? s_ls : d_ls;
    fs = sel ? s_fs : d_fs;
    hc = sel ? {6'd0, s_hc} : d_hc;
    vc = sel ? {6'd0, s_vc} : d_vc;
    pol = sel;
  end

  typedef struct {
    int v, fs, gap, prev, hs_first, hs_last, hs_n, pt_n, br_off, vs_n, br, fgap;
  } ev_t;
  ev_t exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask

  // prev!=0 means the fields hs_first..vs_n describe the line that just ended.
  task automatic push(input int v, input int fsx, input int gap, input int prev,
                      input int hf, input int hl, input int hn, input int ptn,
                      input int bo, input int vn, input int b, input int fg);
    ev_t e;
    e.v = v; e.fs = fsx; e.gap = gap; e.prev = prev; e.hs_first = hf; e.hs_last = hl;
    e.hs_n = hn; e.pt_n = ptn; e.br_off = bo; e.vs_n = vn; e.br = b; e.fgap = fg;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  int cnt, fcnt, hs_first, hs_last, hs_n, pt_n, br_off, vs_n;
  ev_t e;
  always @(negedge clk) begin
    if (clr) begin
      cnt = 0; fcnt = 0; hs_n = 0; pt_n = 0; vs_n = 0;
      br_off = 1023; hs_first = -1; hs_last = -1;
    end else begin
      cnt++;
      fcnt++;
      if (fs && !ls) chk("frame_start_without_line_start", 1, 0);
      if (ls) begin
        if (exp_q.size() == 0) chk("spurious_line_start", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("ls_vcount", int'(vc), e.v);
          chk("ls_hcount", int'(hc), 0);
          chk("ls_frame_start", int'(fs), e.fs);
          chk("ls_bright", int'(br), e.br);
          chk("ls_gap_clk", cnt, e.gap);
          if (e.fgap != 0) chk("frame_period_clk", fcnt, e.fgap);
          if (e.prev != 0) begin
            chk("hsync_first_hcount", hs_first, e.hs_first);
            chk("hsync_last_hcount", hs_last, e.hs_last);
            chk("hsync_width_clk", hs_n, e.hs_n);
            chk("pix_ticks_per_line", pt_n, e.pt_n);
            chk("bright_off_hcount", br_off, e.br_off);
            chk("vsync_clk_in_line", vs_n, e.vs_n);
          end
        end
        cnt = 0; hs_n = 0; pt_n = 0; vs_n = 0;
        br_off = 1023; hs_first = -1; hs_last = -1;
      end
      if (fs) fcnt = 0;
      if (hs == pol) begin
        if (hs_n == 0) hs_first = int'(hc);
        hs_last = int'(hc);
        hs_n++;
      end
      if (vs == pol) vs_n++;
      if (pt) pt_n++;
      if (!br && br_off == 1023) br_off = int'(hc);
    end
  end

  task automatic chk_reset_d(input string tag);
    chk({tag, "_hcount"}, int'(d_hc), 799);
    chk({tag, "_vcount"}, int'(d_vc), 524);
    chk({tag, "_bright"}, int'(d_br), 0);
    chk({tag, "_hsync"}, int'(d_hs), 1);
    chk({tag, "_vsync"}, int'(d_vs), 1);
    chk({tag, "_pix_tick"}, int'(d_pt), 0);
    chk({tag, "_line_start"}, int'(d_ls), 0);
    chk({tag, "_frame_start"}, int'(d_fs), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_d("rst");
    push(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 6; k++) push(k, 0, 1600, 1, 656, 751, 192, 800, 640, 0, 1, 0);
    #2 clr_d = 1'b0;
    drain(12000);
    for (int i = 0; i < 2000 && !(d_hc == 10'd300 && d_vc == 10'd6); i++) @(negedge clk);
    chk("pre_clear_hcount", int'(d_hc), 300);
    chk("pre_clear_vcount", int'(d_vc), 6);
    #2 clr_d = 1'b1;
    #1 chk_reset_d("aclr");
    @(negedge clk);
    push(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    push(1, 0, 1600, 1, 656, 751, 192, 800, 640, 0, 1, 0);
    #2 clr_d = 1'b0;
    drain(4000);
    @(negedge clk);
    #2 clr_d = 1'b1;
    sel = 1'b1;
    repeat (3) @(negedge clk);
    chk("small_rst_hcount", int'(s_hc), 13);
    chk("small_rst_vcount", int'(s_vc), 6);
    chk("small_rst_hsync", int'(s_hs), 0);
    chk("small_rst_vsync", int'(s_vs), 0);
    chk("small_rst_bright", int'(s_br), 0);
    chk("small_rst_pix_tick", int'(s_pt), 0);
    push(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    push(1, 0, 14, 1, 10, 12, 3, 14, 8, 0, 1, 0);
    push(2, 0, 14, 1, 10, 12, 3, 14, 8, 0, 1, 0);
    push(3, 0, 14, 1, 10, 12, 3, 14, 8, 0, 1, 0);
    push(4, 0, 14, 1, 10, 12, 3, 14, 8, 0, 0, 0);
    push(5, 0, 14, 1, 10, 12, 3, 14, 0, 0, 0, 0);
    push(6, 0, 14, 1, 10, 12, 3, 14, 0, 14, 0, 0);
    push(0, 1, 14, 1, 10, 12, 3, 14, 0, 0, 1, 98);
    push(1, 0, 14, 1, 10, 12, 3, 14, 8, 0, 1, 0);
    #2 clr_s = 1'b0;
    drain(300);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
